// File: rtl/fib_seq_gen.sv
// Fibonacci-type stream source: programmable seeds and term count, valid/ready output with abort.
// Define FIB_SEQ_SAT_EN to present overflowed terms as all-ones instead of wrapping modulo 2^WIDTH.
module fib_seq_gen #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             abort,
    input  logic             out_ready,
    output logic [WIDTH-1:0] fib_out,
    output logic             valid,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] cur, nxt;
    logic             cur_wrap, nxt_wrap;
    logic [CNT_W-1:0] remaining;
    logic             ovf_r, done_r;
    logic [WIDTH:0]   sum;
    logic             handshake, is_last;
    logic             accept_start, advance, done_next;

    assign sum       = {1'b0, cur} + {1'b0, nxt};
    assign handshake = (state == RUN) && out_ready;
    assign is_last   = (remaining == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Abort takes priority over a same-cycle handshake; the last beat does not advance the pipeline.
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        advance      = 1'b0;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    if (num_terms != '0) state_next = RUN;
                    else                 done_next  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (handshake) begin
                    if (is_last) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ovf picks up a wrap only as the wrapped term moves onto fib_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= '0;
            nxt       <= '0;
            cur_wrap  <= 1'b0;
            nxt_wrap  <= 1'b0;
            remaining <= '0;
            ovf_r     <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= done_next;
            if (accept_start) begin
                cur       <= seed_a;
                nxt       <= seed_b;
                cur_wrap  <= 1'b0;
                nxt_wrap  <= 1'b0;
                remaining <= num_terms;
                ovf_r     <= 1'b0;
            end else if (advance) begin
                cur       <= nxt;
                cur_wrap  <= nxt_wrap;
                nxt       <= sum[WIDTH-1:0];
                nxt_wrap  <= sum[WIDTH] | cur_wrap | nxt_wrap;
                remaining <= remaining - CNT_W'(1);
                if (nxt_wrap) ovf_r <= 1'b1;
            end
        end
    end

    assign valid = (state == RUN);
    assign busy  = (state == RUN);
    assign last  = valid && is_last;
    assign done  = done_r;
    assign ovf   = ovf_r;

`ifdef FIB_SEQ_SAT_EN
    assign fib_out = cur_wrap ? {WIDTH{1'b1}} : cur;
`else
    assign fib_out = cur;
`endif

endmodule
